// File: rtl/io_pkg.sv
// Shared constants for the I/O buffer: status register bit positions and byte lane width.
package io_pkg;
   localparam int ST_RX_AVAIL   = 0;
   localparam int ST_TX_FULL    = 1;
   localparam int ST_TX_EMPTY   = 2;
   localparam int ST_RX_OVF     = 3;
   localparam int ST_RX_CNT_LSB = 16;
   localparam int BYTE_W        = 8;
endpackage

// File: rtl/io_buffer_sync_fifo.sv
// Single-clock FIFO with wrapping pointers and an occupancy count one bit wider than the pointers.
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
   localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
   localparam logic [DEPTH_LOG2:0]   CNT_MAX = (DEPTH_LOG2+1)'(DEPTH);

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  w_push;
   logic                  w_pop;

   assign empty  = (r_count == '0);
   assign full   = (r_count == CNT_MAX);
   assign count  = r_count;
   assign w_pop  = pop & ~empty;
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign w_push = push & (~full | w_pop);
   assign dout   = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end
endmodule

// File: rtl/io_buffer.sv
// Core-side I/O buffer: assembles UART RX bytes into words for the core and queues core output
// bytes for the UART transmitter.
module io_buffer
   import io_pkg::*;
#(
   parameter int RX_DEPTH_LOG2 = 8,
   parameter int TX_DEPTH_LOG2 = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        out_issued,
   input  logic [31:0] out_data,
   output logic        out_stall,
   input  logic        in_issued,
   output logic [31:0] in_data,
   output logic        in_stall,
   output logic [31:0] status,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
);
   logic [1:0]               r_byte_cnt;
   logic [23:0]              r_shift;
   logic                     r_ovf;
   logic                     w_rx_push;
   logic                     w_rx_pop;
   logic [31:0]              w_rx_word;
   logic [RX_DEPTH_LOG2:0]   w_rx_count;
   logic                     w_rx_full;
   logic                     w_rx_empty;
   logic                     w_tx_push;
   logic                     w_tx_pop;
   logic [TX_DEPTH_LOG2:0]   w_tx_count;
   logic                     w_tx_full;
   logic                     w_tx_empty;
   logic                     w_unused_out_hi;

   assign w_unused_out_hi = ^{out_data[31:BYTE_W], w_tx_count};

   assign w_rx_push = rx_valid & (r_byte_cnt == 2'd3);
   assign w_rx_word = {rx_data, r_shift};
   assign in_stall  = in_issued & w_rx_empty;
   assign w_rx_pop  = in_issued & ~w_rx_empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_byte_cnt <= 2'd0;
         r_shift    <= '0;
         r_ovf      <= 1'b0;
      end else begin
         if (rx_valid) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
               2'd0:    r_shift[7:0]   <= rx_data;
               2'd1:    r_shift[15:8]  <= rx_data;
               2'd2:    r_shift[23:16] <= rx_data;
               default: r_shift        <= r_shift;
            endcase
         end
         if (w_rx_push && w_rx_full && !w_rx_pop) r_ovf <= 1'b1;
      end
   end

   sync_fifo #(.WIDTH(32), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_rx_push),
      .pop   (w_rx_pop),
      .din   (w_rx_word),
      .dout  (in_data),
      .count (w_rx_count),
      .full  (w_rx_full),
      .empty (w_rx_empty)
   );

   // Stall decision uses the registered full flag only; a same-cycle drain does not help.
   assign out_stall = out_issued & w_tx_full;
   assign w_tx_push = out_issued & ~w_tx_full;
   assign tx_valid  = ~w_tx_empty;
   assign w_tx_pop  = tx_valid & tx_ready;

   sync_fifo #(.WIDTH(BYTE_W), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_tx_push),
      .pop   (w_tx_pop),
      .din   (out_data[BYTE_W-1:0]),
      .dout  (tx_data),
      .count (w_tx_count),
      .full  (w_tx_full),
      .empty (w_tx_empty)
   );

   always_comb begin
      status                      = '0;
      status[ST_RX_AVAIL]         = ~w_rx_empty;
      status[ST_TX_FULL]          = w_tx_full;
      status[ST_TX_EMPTY]         = w_tx_empty;
      status[ST_RX_OVF]           = r_ovf;
      status[ST_RX_CNT_LSB +: 16] = 16'(w_rx_count);
   end
endmodule

// File: tb/tb_io_buffer.sv
// Directed bench for io_buffer with scoreboard queues for RX words and TX bytes.
module tb_io_buffer;
   logic        clk = 1'b0;
   logic        rst;
   logic        out_issued;
   logic [31:0] out_data;
   logic        out_stall;
   logic        in_issued;
   logic [31:0] in_data;
   logic        in_stall;
   logic [31:0] status;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;

   int checks   = 0;
   int failures = 0;
   logic [31:0] rx_q[$];
   logic [7:0]  tx_q[$];

   always #5 clk = ~clk;

   io_buffer dut (
      .clk(clk), .rst(rst),
      .out_issued(out_issued), .out_data(out_data), .out_stall(out_stall),
      .in_issued(in_issued), .in_data(in_data), .in_stall(in_stall),
      .status(status),
      .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rx_pop();
      if (rx_q.size() == 0) return 32'hxxxx_xxxx;
      return rx_q.pop_front();
   endfunction

   function automatic logic [7:0] tx_pop();
      if (tx_q.size() == 0) return 8'hxx;
      return tx_q.pop_front();
   endfunction

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   initial begin
      logic [7:0]  b;
      logic [31:0] w;
      rst = 1'b0; out_issued = 1'b0; out_data = '0; in_issued = 1'b0;
      rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
      tick(); tick();
      rst = 1'b1;
      in_issued = 1'b1;
      #1;
      chk("reset_status", status, 32'h0000_0004);
      chk("reset_in_stall", {31'b0, in_stall}, 32'd1);
      chk("reset_tx_valid", {31'b0, tx_valid}, 32'd0);
      chk("reset_in_data", in_data, 32'd0);

      // RX word assembly with the core already waiting
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      chk("rx_stall_before_4th", {31'b0, in_stall}, 32'd1);
      rx_q.push_back(32'h4433_2211);
      send_byte(8'h44);
      chk("rx_unstall", {31'b0, in_stall}, 32'd0);
      chk("rx_count_one", {16'b0, status[31:16]}, 32'd1);
      chk("rx_word", in_data, rx_pop());
      tick();
      chk("rx_restall", {31'b0, in_stall}, 32'd1);
      chk("rx_count_zero", {16'b0, status[31:16]}, 32'd0);
      chk("rx_empty_data", in_data, 32'd0);
      in_issued = 1'b0;

      // single TX byte, held then drained
      out_issued = 1'b1; out_data = 32'hDEAD_BEEF;
      tx_q.push_back(8'hEF);
      tick();
      out_issued = 1'b0;
      chk("tx_valid_set", {31'b0, tx_valid}, 32'd1);
      chk("tx_data_head", {24'b0, tx_data}, {24'b0, tx_q[0]});
      tick();
      chk("tx_data_stable", {24'b0, tx_data}, {24'b0, tx_q[0]});
      tx_ready = 1'b1;
      #1;
      chk("tx_data_pop", {24'b0, tx_data}, {24'b0, tx_pop()});
      tick();
      tx_ready = 1'b0;
      #1;
      chk("tx_valid_clear", {31'b0, tx_valid}, 32'd0);
      chk("tx_empty_bit", {31'b0, status[2]}, 32'd1);

      // fill TX completely
      out_issued = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         out_data = 32'(i) | 32'hABCD_0000;
         tx_q.push_back(8'(i));
         tick();
      end
      out_issued = 1'b0;
      #1;
      chk("tx_full_bit", {31'b0, status[1]}, 32'd1);
      out_issued = 1'b1; out_data = 32'h0000_00A5; tx_ready = 1'b1;
      #1;
      chk("tx_stall_with_ready", {31'b0, out_stall}, 32'd1);
      chk("tx_full_head", {24'b0, tx_data}, {24'b0, tx_pop()});
      tick();
      tx_ready = 1'b0;
      #1;
      chk("tx_unstall_next", {31'b0, out_stall}, 32'd0);
      tx_q.push_back(8'hA5);
      tick();
      out_issued = 1'b0;
      tx_ready = 1'b1;
      #1;
      for (int i = 0; i < 1024; i++) begin
         chk("tx_drain", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, tx_pop()});
         tick();
      end
      tx_ready = 1'b0;
      #1;
      chk("tx_drained_empty", {31'b0, status[2]}, 32'd1);
      chk("tx_drained_valid", {31'b0, tx_valid}, 32'd0);

      // fill RX completely, then overflow
      for (int wi = 0; wi < 256; wi++) begin
         for (int k = 0; k < 4; k++) begin
            b = 8'(wi * 4 + k);
            w[k*8 +: 8] = b;
            send_byte(b);
         end
         rx_q.push_back(w);
      end
      #1;
      chk("rx_full_count", {16'b0, status[31:16]}, 32'd256);
      chk("rx_no_ovf_yet", {31'b0, status[3]}, 32'd0);
      send_byte(8'hE0); send_byte(8'hE1); send_byte(8'hE2); send_byte(8'hE3);
      chk("rx_ovf_set", {31'b0, status[3]}, 32'd1);
      chk("rx_ovf_count", {16'b0, status[31:16]}, 32'd256);
      send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hC2);
      in_issued = 1'b1; rx_valid = 1'b1; rx_data = 8'hC3;
      #1;
      chk("rx_concurrent_pop", in_data, rx_pop());
      rx_q.push_back(32'hC3C2_C1C0);
      tick();
      rx_valid = 1'b0; in_issued = 1'b0;
      #1;
      chk("rx_concurrent_count", {16'b0, status[31:16]}, 32'd256);
      chk("rx_concurrent_ovf", {31'b0, status[3]}, 32'd1);
      in_issued = 1'b1;
      #1;
      for (int i = 0; i < 256; i++) begin
         chk("rx_drain", {in_stall, in_data[30:0]} ^ {in_data[31], 31'b0}, rx_pop());
         tick();
      end
      chk("rx_drained_stall", {31'b0, in_stall}, 32'd1);
      in_issued = 1'b0;

      // reset in the middle of a partial word
      send_byte(8'hAA); send_byte(8'hBB);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("midreset_status", status, 32'h0000_0004);
      rx_q.push_back(32'h0403_0201);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      in_issued = 1'b1;
      #1;
      chk("midreset_word", in_data, rx_pop());
      chk("midreset_count", {16'b0, status[31:16]}, 32'd1);
      tick();
      in_issued = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
